instr_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the synchronous-read instruction RAM.
- Generates the RAM read address each cycle and absorbs the RAM's one-cycle read latency.
- Handles stall and branch/jump redirect.
- Presents a valid instruction/PC pair to decode, which reads the regfile.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction-fetch stage in front of a synchronous-read instruction RAM
//
// Purpose:
//   Drives the instruction RAM read address every cycle and absorbs the RAM's
//   one-cycle read latency. It handles stall (re-read the same word) and
//   redirect (restart at a new word index). It hands a valid instruction/PC
//   pair to decode.
//
// Ports:
//   clk          in   1           single clock, posedge
//   reset        in   1           asynchronous, active-high
//   stall        in   1           decode cannot accept; hold current instruction
//   redirect     in   1           taken branch/jump; restart fetch at redirect_pc
//   redirect_pc  in   PC_WIDTH    redirect target word index
//   imem_addr    out  PC_WIDTH    RAM read address (combinational)
//   imem_dout    in   DATA_WIDTH  RAM read data for the address sampled last posedge
//   instr_out    out  DATA_WIDTH  instruction to decode (equals imem_dout)
//   pc_out       out  PC_WIDTH    word index of instr_out
//   instr_valid  out  1           instr_out/pc_out meaningful
//   perf_fetched out  32          (INSTR_FETCH_PERF_EN only) RUN cycles delivering an instruction
//   perf_stalled out  32          (INSTR_FETCH_PERF_EN only) RUN cycles held by stall
//
// Optional feature macro: INSTR_FETCH_PERF_EN

module instr_fetch #(
  parameter int PC_WIDTH   = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]   pc_out,
`ifdef INSTR_FETCH_PERF_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stalled,
`endif
  output logic                  instr_valid
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PC_WIDTH-1:0] LP_RESET_PC = PC_WIDTH'(RESET_PC);

  logic [0:0]          r_state;
  logic [PC_WIDTH-1:0] r_f_pc;     // address whose data is on imem_dout now
  logic                r_f_valid;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_next_pc;

  // Natural modulo-2^PC_WIDTH wrap; no bubble on rollover.
  assign w_pc_inc = r_f_pc + PC_WIDTH'(1);

  // The next-address choice is also the value f_pc takes at the next posedge.
  // So the RAM address and the registered PC can never disagree.
  always_comb begin
    w_next_pc = w_pc_inc;
    if (reset) begin
      w_next_pc = LP_RESET_PC;
    end else if (redirect) begin
      w_next_pc = redirect_pc;
    end else if (r_state == ST_BOOT) begin
      w_next_pc = LP_RESET_PC;
    end else if (stall) begin
      w_next_pc = r_f_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_BOOT;
      r_f_pc    <= LP_RESET_PC;
      r_f_valid <= 1'b0;
    end else begin
      r_state   <= ST_RUN;
      r_f_pc    <= w_next_pc;
      r_f_valid <= 1'b1;
    end
  end

  assign imem_addr   = w_next_pc;
  assign instr_out   = imem_dout;
  assign pc_out      = r_f_pc;
  // Registered only: no combinational path from stall/redirect to valid.
  assign instr_valid = r_f_valid;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalled;
  logic        w_run_active;

  assign w_run_active = (r_state == ST_RUN) && r_f_valid && !redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_stalled <= 32'd0;
    end else if (w_run_active) begin
      if (stall) begin
        r_perf_stalled <= r_perf_stalled + 32'd1;
      end else begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalled = r_perf_stalled;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] instr_out;
  logic [8:0]  pc_out;
  logic        instr_valid;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  logic [31:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(9), .DATA_WIDTH(32), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
`ifdef INSTR_FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled),
`endif
    .instr_valid (instr_valid)
  );

  // Synchronous-read RAM model, preloaded mem[i] = i + 100.
  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input int pc, input int ins);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, 32'(pc_out), 32'(pc));
    chk({tag, "_instr"}, instr_out, 32'(ins));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'(i + 100);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
    chk("rst_pf", perf_fetched, 32'd0);
    chk("rst_ps", perf_stalled, 32'd0);
`endif

    // BOOT cycle then sequential fetch
    reset = 1'b0;
    #1;
    chk("boot_valid", 32'(instr_valid), 32'd0);
    chk("boot_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_fetch("seq", i, 100 + i);
    end

    // Stall for 3 cycles at pc 5
    stall = 1'b1;
    #1 chk("stall_addr0", 32'(imem_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_fetch("stall", 5, 105);
      chk("stall_addr", 32'(imem_addr), 32'd5);
    end
    stall = 1'b0;
    #1 chk("unstall_addr", 32'(imem_addr), 32'd6);
    @(negedge clk); chk_fetch("unstall", 6, 106);
    @(negedge clk); chk_fetch("pre_redir", 7, 107);

    // Redirect to 40
    redirect = 1'b1; redirect_pc = 9'd40;
    #1 chk("redir_addr", 32'(imem_addr), 32'd40);
    @(negedge clk); redirect = 1'b0;
    chk_fetch("redir", 40, 140);
    @(negedge clk); chk_fetch("redir_next", 41, 141);

    // Simultaneous stall and redirect: redirect wins
    stall = 1'b1; redirect = 1'b1; redirect_pc = 9'd12;
    #1 chk("sr_addr", 32'(imem_addr), 32'd12);
    @(negedge clk); redirect = 1'b0;
    chk_fetch("sr", 12, 112);
    #1 chk("sr_hold_addr", 32'(imem_addr), 32'd12);
    @(negedge clk); chk_fetch("sr_hold", 12, 112);
    stall = 1'b0;
    @(negedge clk); chk_fetch("sr_go", 13, 113);

    // Wrap at 511
    redirect = 1'b1; redirect_pc = 9'd511;
    @(negedge clk); redirect = 1'b0;
    chk_fetch("wrap511", 511, 611);
    #1 chk("wrap_addr", 32'(imem_addr), 32'd0);
    @(negedge clk); chk_fetch("wrap0", 0, 100);
    @(negedge clk); chk_fetch("wrap1", 1, 101);

    // Reset mid-stream at pc 20
    redirect = 1'b1; redirect_pc = 9'd20;
    @(negedge clk); redirect = 1'b0;
    chk_fetch("pre_rst", 20, 120);
    #1 reset = 1'b1;
    #1;
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_pc", 32'(pc_out), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
    chk("mrst_pf", perf_fetched, 32'd0);
    chk("mrst_ps", perf_stalled, 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("mboot_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); chk_fetch("mboot0", 0, 100);
    @(negedge clk); chk_fetch("mboot1", 1, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
